// File: rtl/lstm_pkg.sv
// Shared constants and types for the LSTM step sequencer and the cell it wraps.
package lstm_pkg;
    localparam int N       = 8;
    localparam int S       = 8;
    localparam int VEC_W   = S * N;
    localparam int LAT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/lstm_hist_shift.sv
// S-entry, N-bit hidden-state history; newest entry sits in the low N bits.
module lstm_hist_shift
    import lstm_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] din,
    output vec_t         q
);
    vec_t hist_d;
    vec_t hist_q;

    // Clear wins over load so a sequence end discards the final h_t.
    always_comb begin
        hist_d = hist_q;
        if (clear) begin
            hist_d = '0;
        end else if (load) begin
            hist_d = {hist_q[VEC_W-N-1:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign q = hist_q;
endmodule

// File: rtl/lstm_step_sequencer.sv
// Steps one LSTM cell through a sequence: accepts x_t, waits LAT cycles,
// captures h_t/c_t, hands the result out and feeds it back as history.
module lstm_step_sequencer
    import lstm_pkg::*;
#(
    parameter int LAT    = LAT_DEF,
    parameter int STEP_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_xt,
    input  logic              in_first,
    input  logic              in_last,
    output logic [VEC_W-1:0]  cell_xt,
    output logic [VEC_W-1:0]  cell_ht1,
    output logic [N-1:0]      cell_ct1,
    input  logic [N-1:0]      cell_ht,
    input  logic [N-1:0]      cell_ct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_ht,
    output logic [N-1:0]      out_ct,
    output logic [STEP_W-1:0] out_step,
    output logic              out_last
);
    localparam int CNT_W = $clog2(LAT + 1);

    state_t              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [STEP_W-1:0]   step_d, step_q;
    logic                last_flag_d, last_flag_q;
    logic                in_ready_d, in_ready_q;
    logic                out_valid_d, out_valid_q;
    logic [VEC_W-1:0]    xt_d, xt_q;
    logic [N-1:0]        ct1_d, ct1_q;
    logic [N-1:0]        out_ht_d, out_ht_q;
    logic [N-1:0]        out_ct_d, out_ct_q;
    logic [STEP_W-1:0]   out_step_d, out_step_q;
    logic                out_last_d, out_last_q;
    logic                hist_clear;
    logic                hist_load;

    // Cell inputs only move at the accept edge or the output handshake edge,
    // so they stay constant for the whole WAIT interval.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        last_flag_d = last_flag_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        xt_d        = xt_q;
        ct1_d       = ct1_q;
        out_ht_d    = out_ht_q;
        out_ct_d    = out_ct_q;
        out_step_d  = out_step_q;
        out_last_d  = out_last_q;
        hist_clear  = 1'b0;
        hist_load   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    xt_d        = in_xt;
                    last_flag_d = in_last;
                    if (in_first) begin
                        ct1_d      = '0;
                        step_d     = '0;
                        hist_clear = 1'b1;
                    end
                    cnt_d      = CNT_W'(LAT);
                    in_ready_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_ht_d    = cell_ht;
                    out_ct_d    = cell_ct;
                    out_step_d  = step_q;
                    out_last_d  = last_flag_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        hist_clear = 1'b1;
                        ct1_d      = '0;
                        step_d     = '0;
                    end else begin
                        hist_load = 1'b1;
                        ct1_d     = out_ct_q;
                        step_d    = step_q + STEP_W'(1);
                    end
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            last_flag_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            xt_q        <= '0;
            ct1_q       <= '0;
            out_ht_q    <= '0;
            out_ct_q    <= '0;
            out_step_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            last_flag_q <= last_flag_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            xt_q        <= xt_d;
            ct1_q       <= ct1_d;
            out_ht_q    <= out_ht_d;
            out_ct_q    <= out_ct_d;
            out_step_q  <= out_step_d;
            out_last_q  <= out_last_d;
        end
    end

    lstm_hist_shift u_hist (
        .clk   (CLOCK_50),
        .reset (reset),
        .clear (hist_clear),
        .load  (hist_load),
        .din   (out_ht_q),
        .q     (cell_ht1)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign cell_xt   = xt_q;
    assign cell_ct1  = ct1_q;
    assign out_ht    = out_ht_q;
    assign out_ct    = out_ct_q;
    assign out_step  = out_step_q;
    assign out_last  = out_last_q;
endmodule
